// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Multi-cycle data-memory responder for the memory stage. A request
//   (enable/wr/addr/data_in) is captured on acceptance, the responder stays
//   busy for LAT cycles, then performs the access and pulses done for one
//   cycle with registered read data and a misalignment flag.
//
// Parameters
//   DEPTH_LOG2 : word-address bits; storage is 2^DEPTH_LOG2 x 16-bit words
//   LAT        : cycles from acceptance to done (1..15)
//
// Ports
//   clk      in  : clock, rising edge
//   rst      in  : asynchronous active-low reset
//   enable   in  : access request
//   wr       in  : 1 = write, 0 = read (qualified by enable)
//   addr     in  : byte address, word index = addr[DEPTH_LOG2:1]
//   data_in  in  : write data
//   stall    out : busy, requester must hold its inputs
//   done     out : one-cycle completion strobe
//   data_out out : read data, valid while done, held until next completion
//   err      out : misaligned-access flag, valid while done, held likewise
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LAT        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic        stall,
  output logic        done,
  output logic [15:0] data_out,
  output logic        err
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic                  mis_q, mis_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [15:0]           data_out_q, data_out_d;
  logic                  err_q, err_d;
  logic                  mem_we;
  logic [15:0]           mem_q [DEPTH];

  // Address bits above the word index are deliberately ignored (aliasing).
  generate
    if (DEPTH_LOG2 < 15) begin : g_unused
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[15:DEPTH_LOG2+1];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    mis_d      = mis_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    err_d      = err_q;
    mem_we     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (enable) begin
          state_d = S_BUSY;
          cnt_d   = CNT_INIT;
          wr_d    = wr;
          mis_d   = addr[0];
          idx_d   = addr[DEPTH_LOG2:1];
          wdata_d = data_in;
        end
      end
      S_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // The access itself happens on the BUSY->DONE edge, using only the
          // copies captured at acceptance.
          state_d = S_DONE;
          if (mis_q) begin
            data_out_d = 16'd0;
            err_d      = 1'b1;
          end else if (wr_q) begin
            mem_we     = 1'b1;
            data_out_d = 16'd0;
            err_d      = 1'b0;
          end else begin
            data_out_d = mem_q[idx_q];
            err_d      = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      data_out_q <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      err_q      <= err_d;
    end
  end

  // Request capture registers only matter once a request has been accepted.
  always_ff @(posedge clk) begin
    wr_q    <= wr_d;
    mis_q   <= mis_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 16'd0;
    end else if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign stall    = (state_q == S_BUSY);
  assign done     = (state_q == S_DONE);
  assign data_out = data_out_q;
  assign err      = err_q;

endmodule
